booth_multiplier_seq: RTL and testbench
=======================================

// Module: booth_multiplier_seq
// PURPOSE
//   Parametrised sequential radix-2 Booth multiplier: one Booth step per clock.
//   Generalises the 4-bit multiplier to WIDTH-bit operands with a per-operation
//   signed/unsigned mode and a start/busy/done handshake.
//   Sits between the operand registers and the result bus of the arithmetic datapath.
// PARAMETERS
//   WIDTH   8   operand width in bits (legal range 2..32); product is 2*WIDTH bits
// PORTS
//   clock        in   1        rising-edge clock
//   reset        in   1        asynchronous, active-high reset
//   start        in   1        request a multiply; accepted only when busy==0
//   signed_mode  in   1        1: A,B two's complement; 0: A,B unsigned (captured with start)
//   A            in   WIDTH    multiplicand (captured with start)
//   B            in   WIDTH    multiplier (captured with start)
//   P            out  2*WIDTH  product register; updated only at completion
//   busy         out  1        high while an operation is in progress
//   done         out  1        one-cycle pulse: P holds a new result
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, P=0, busy=0, done=0, count=0, internal regs=0.
//     Reset mid-operation aborts it; no done pulse and P=0 after reset.
//   States: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: busy=0, done=0. start=1 -> capture operands, go RUN, count=0.
//     RUN : busy=1. One Booth step per edge; after step WIDTH+1 go DONE and load P.
//     DONE: busy=0, done=1 for exactly this cycle. start=1 here is accepted
//           (back-to-back, same as IDLE accept); otherwise -> IDLE.
//   start while busy=1 is ignored (no queueing); A/B/signed_mode changes after
//     capture do not affect the operation in flight.
//   Latency: start accepted at edge e0 -> done=1 and P valid after edge e0+WIDTH+1.
//     Throughput: one result per WIDTH+2 cycles back-to-back.
//   Operand extension: M = A and Q = B each extended to WIDTH+1 bits --
//     sign-extended if signed_mode=1, zero-extended if 0. This makes
//     unsigned mode exact with the same signed Booth core.
//   Datapath: acc (WIDTH+2 bits, signed), q (WIDTH+1 bits), q_m1 (1 bit, init 0).
//     Each step decodes {q[0],q_m1}:
//       00/11 no add; 01 acc+=sext(M); 10 acc-=sext(M).
//     Then arithmetic right shift of {acc,q,q_m1} by 1 (acc MSB replicated).
//   Result: P = low 2*WIDTH bits of {acc,q} after WIDTH+1 steps. This is always
//     the exact product: signed range fits 2*WIDTH bits, and so does the
//     unsigned range. No overflow flag.
//   Most-negative operands (e.g. -2^(WIDTH-1) * -2^(WIDTH-1)) must be exact.
//     The acc guard bit guarantees this; no saturation anywhere.
//   P holds its value through IDLE/RUN of later operations until the next DONE.
// TESTING (WIDTH=8 unless stated)
//   1 signed: A=-3 (0xFD), B=5, sm=1 -> done 9 cycles after accept, P=0xFFF1 (-15)
//   2 corner: A=B=0x80, sm=1 -> P=0x4000; same operands sm=0 -> P=0x4000 (128*128)
//   3 unsigned: A=B=0xFF, sm=0 -> P=0xFE01; same operands sm=1 -> P=0x0001
//   4 handshake: start held high through RUN -> ignored; start=1 in DONE cycle
//     (A=7,B=-2,sm=1) -> second done 10 cycles after first, P=0xFFF2; busy low only in DONE
//   5 reset mid-RUN (step 4) -> busy=0, done=0, P=0 immediately (async); no done pulse;
//     next start completes normally
//   6 WIDTH=4 instance: A=-8,B=-8,sm=1 -> P=0x40; A=15,B=15,sm=0 -> P=0xE1;
//     random self-check vs A*B for 1000 ops each mode

Source files
------------

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
// Operands are extended to WIDTH+1 bits so that one signed Booth core covers
// both signed and unsigned multiplies exactly. The accumulator carries one
// extra guard bit, so even the most-negative operand pairs never overflow.
// Handshake: start is accepted in IDLE or DONE. busy is high during RUN.
// done pulses for the single cycle in which P holds a fresh product.
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  // Extended operand width, accumulator width (extra guard bit), step counter width
  localparam int EW = WIDTH + 1;
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);
  localparam int SW = AW + EW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [EW-1:0]   m;
  logic [AW-1:0]   acc;
  logic [EW-1:0]   q;
  logic            qm1;
  logic [CW-1:0]   count;

  logic [EW-1:0]   extA;
  logic [EW-1:0]   extB;
  logic [AW-1:0]   mExt;
  logic [AW-1:0]   sum;
  logic [SW-1:0]   shifted;
  logic [AW-1:0]   accNext;
  logic [EW-1:0]   qNext;
  logic            qm1Next;
  logic [2*WIDTH-1:0] productNext;
  logic            lastStep;
  logic            accept;

  // Sign- or zero-extend the incoming operands depending on the requested mode
  assign extA = {signed_mode & A[WIDTH-1], A};
  assign extB = {signed_mode & B[WIDTH-1], B};

  // The multiplicand is sign-extended once more to line up with the guarded accumulator
  assign mExt = {m[EW-1], m};

  // Booth decode of {q[0], q_m1}: add, subtract or pass the multiplicand
  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + mExt;
      2'b10:   sum = acc - mExt;
      default: sum = acc;
    endcase
  end

  // Arithmetic right shift of {sum, q, q_m1}: the old q_m1 falls off the end
  assign shifted     = {sum[AW-1], sum, q};
  assign accNext     = shifted[SW-1:EW+1];
  assign qNext       = shifted[EW:1];
  assign qm1Next     = shifted[0];
  assign productNext = shifted[2*WIDTH:1];

  // The step taken while count equals WIDTH is the (WIDTH+1)th and final one
  assign lastStep = (count == CW'(WIDTH));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // Control FSM and Booth datapath, with registered busy/done/P
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      count <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            m     <= extA;
            q     <= extB;
            acc   <= '0;
            qm1   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= accNext;
          q     <= qNext;
          qm1   <= qm1Next;
          count <= count + CW'(1);
          if (lastStep) begin
            P     <= productNext;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Testbench for booth_multiplier_seq: an 8-bit and a 4-bit instance.
// Expected products are pushed into per-instance queues when an operation
// is launched and popped by a monitor whenever the DUT raises done.
module tb_booth_multiplier_seq;

  logic        clock;
  logic        reset;

  logic        start8;
  logic        sm8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] p8;
  logic        busy8;
  logic        done8;

  logic        start4;
  logic        sm4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic [7:0]  p4;
  logic        busy4;
  logic        done4;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clock       (clock),
    .reset       (reset),
    .start       (start8),
    .signed_mode (sm8),
    .A           (a8),
    .B           (b8),
    .P           (p8),
    .busy        (busy8),
    .done        (done8)
  );

  booth_multiplier_seq #(.WIDTH(4)) dut4 (
    .clock       (clock),
    .reset       (reset),
    .start       (start4),
    .signed_mode (sm4),
    .A           (a4),
    .B           (b4),
    .P           (p4),
    .busy        (busy4),
    .done        (done4)
  );

  // Free-running clock, 10 ns period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference product for the 8-bit instance
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    longint x;
    if (sm) x = longint'($signed(a)) * longint'($signed(b));
    else    x = longint'(a) * longint'(b);
    return x[15:0];
  endfunction

  // Reference product for the 4-bit instance
  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    longint x;
    if (sm) x = longint'($signed(a)) * longint'($signed(b));
    else    x = longint'(a) * longint'(b);
    return x[7:0];
  endfunction

  // Scoreboard for the 8-bit instance: every done pops one expected product
  always @(negedge clock) begin
    if (!reset && done8 === 1'b1) begin
      testsRun++;
      if (q8.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL sb8_unexpected_done: got P=%h with nothing expected", p8);
      end else begin
        logic [15:0] exp8;
        exp8 = q8.pop_front();
        if (p8 !== exp8) begin
          testsFailed++;
          $display("[TB] FAIL sb8_product: got P=%h, expected %h", p8, exp8);
        end
      end
    end
  end

  // Scoreboard for the 4-bit instance
  always @(negedge clock) begin
    if (!reset && done4 === 1'b1) begin
      testsRun++;
      if (q4.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL sb4_unexpected_done: got P=%h with nothing expected", p4);
      end else begin
        logic [7:0] exp4;
        exp4 = q4.pop_front();
        if (p4 !== exp4) begin
          testsFailed++;
          $display("[TB] FAIL sb4_product: got P=%h, expected %h", p4, exp4);
        end
      end
    end
  end

  // Launch one 8-bit operation; returns #1 after the accepting edge
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm, input bit push);
    @(posedge clock); #1;
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    if (push) q8.push_back(model8(a, b, sm));
    @(posedge clock); #1;
    start8 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    @(posedge clock); #1;
    a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
    q4.push_back(model4(a, b, sm));
    @(posedge clock); #1;
    start4 = 1'b0;
  endtask

  // Count edges until done; -1 means the bound ran out
  task automatic waitDone8(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (done8) begin
        cycles = c;
        return;
      end
    end
  endtask

  task automatic waitDone4(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (done4) begin
        cycles = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    testsRun++;
    if ({p8, busy8, done8} !== 18'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset8: got P=%h busy=%b done=%b, expected all zero", p8, busy8, done8);
    end
    testsRun++;
    if ({p4, busy4, done4} !== 10'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset4: got P=%h busy=%b done=%b, expected all zero", p4, busy4, done4);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    testsRun++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, expected 0/0", busy8, done8);
    end
  endtask

  task automatic test_signed();
    int cyc;
    issue8(8'hFD, 8'h05, 1'b1, 1'b1);
    testsRun++;
    if (busy8 !== 1'b1 || p8 !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL signed_run: busy=%b P=%h, expected busy=1 P=0000", busy8, p8);
    end
    waitDone8(cyc);
    testsRun++;
    if (cyc != 9) begin
      testsFailed++;
      $display("[TB] FAIL signed_latency: got %0d cycles, expected 9", cyc);
    end
    testsRun++;
    if (p8 !== 16'hFFF1 || busy8 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL signed_product: got P=%h busy=%b, expected FFF1 busy=0", p8, busy8);
    end
    @(posedge clock); #1;
    testsRun++;
    if (done8 !== 1'b0 || p8 !== 16'hFFF1) begin
      testsFailed++;
      $display("[TB] FAIL done_pulse: done=%b P=%h, expected done=0 P=FFF1", done8, p8);
    end
  endtask

  task automatic test_corner();
    int cyc;
    issue8(8'h80, 8'h80, 1'b1, 1'b1);
    waitDone8(cyc);
    testsRun++;
    if (cyc != 9 || p8 !== 16'h4000) begin
      testsFailed++;
      $display("[TB] FAIL corner_signed: got P=%h after %0d cycles, expected 4000 after 9", p8, cyc);
    end
    issue8(8'h80, 8'h80, 1'b0, 1'b1);
    testsRun++;
    if (p8 !== 16'h4000) begin
      testsFailed++;
      $display("[TB] FAIL p_hold: got P=%h during RUN, expected 4000", p8);
    end
    waitDone8(cyc);
    testsRun++;
    if (cyc != 9 || p8 !== 16'h4000) begin
      testsFailed++;
      $display("[TB] FAIL corner_unsigned: got P=%h after %0d cycles, expected 4000 after 9", p8, cyc);
    end
  endtask

  task automatic test_unsigned();
    int cyc;
    issue8(8'hFF, 8'hFF, 1'b0, 1'b1);
    waitDone8(cyc);
    testsRun++;
    if (cyc != 9 || p8 !== 16'hFE01) begin
      testsFailed++;
      $display("[TB] FAIL unsigned_ff: got P=%h after %0d cycles, expected FE01 after 9", p8, cyc);
    end
    issue8(8'hFF, 8'hFF, 1'b1, 1'b1);
    waitDone8(cyc);
    testsRun++;
    if (cyc != 9 || p8 !== 16'h0001) begin
      testsFailed++;
      $display("[TB] FAIL signed_ff: got P=%h after %0d cycles, expected 0001 after 9", p8, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int firstGap;
    int cyc;
    int busyLow;
    busyLow  = 0;
    firstGap = -1;
    // start stays high for the whole first operation while A/B/mode churn
    @(posedge clock); #1;
    a8 = 8'd3; b8 = 8'd4; sm8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'd3, 8'd4, 1'b0));
    @(posedge clock); #1;
    for (int c = 1; c <= 40; c++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sm8 = 1'($urandom);
      @(posedge clock); #1;
      if (done8) begin
        firstGap = c;
        break;
      end
      if (busy8 !== 1'b1) busyLow++;
    end
    testsRun++;
    if (firstGap != 9 || busyLow != 0) begin
      testsFailed++;
      $display("[TB] FAIL held_start: done after %0d cycles, busy low %0d times, expected 9 and 0", firstGap, busyLow);
    end
    testsRun++;
    if (busy8 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL busy_in_done: got busy=%b, expected 0", busy8);
    end
    // start is still high in the DONE cycle: second operation goes back-to-back
    a8 = 8'd7; b8 = 8'hFE; sm8 = 1'b1;
    q8.push_back(model8(8'd7, 8'hFE, 1'b1));
    @(posedge clock); #1;
    start8 = 1'b0;
    testsRun++;
    if (busy8 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_accept: got busy=%b, expected 1", busy8);
    end
    waitDone8(cyc);
    testsRun++;
    if (cyc != 9 || p8 !== 16'hFFF2) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: got P=%h, %0d cycles after first done, expected FFF2 after 10", p8, cyc + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int doneSeen;
    int cyc;
    doneSeen = 0;
    issue8(8'h55, 8'h33, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    testsRun++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: busy=%b done=%b P=%h, expected 0/0/0000", busy8, done8, p8);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clock); #1;
      if (done8 !== 1'b0) doneSeen++;
    end
    testsRun++;
    if (doneSeen != 0 || p8 !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL aborted_op: done seen %0d times, P=%h, expected 0 and 0000", doneSeen, p8);
    end
    issue8(8'h12, 8'h34, 1'b0, 1'b1);
    waitDone8(cyc);
    testsRun++;
    if (cyc != 9 || p8 !== 16'h03A8) begin
      testsFailed++;
      $display("[TB] FAIL after_reset_op: got P=%h after %0d cycles, expected 03A8 after 9", p8, cyc);
    end
  endtask

  task automatic test_random8();
    int cyc;
    for (int i = 0; i < 200; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'(i % 2), 1'b1);
      waitDone8(cyc);
      if (cyc < 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL random8_timeout: op %0d never finished", i);
      end
    end
  endtask

  task automatic test_width4();
    int cyc;
    issue4(4'h8, 4'h8, 1'b1);
    waitDone4(cyc);
    testsRun++;
    if (cyc != 5 || p4 !== 8'h40) begin
      testsFailed++;
      $display("[TB] FAIL w4_most_negative: got P=%h after %0d cycles, expected 40 after 5", p4, cyc);
    end
    issue4(4'hF, 4'hF, 1'b0);
    waitDone4(cyc);
    testsRun++;
    if (cyc != 5 || p4 !== 8'hE1) begin
      testsFailed++;
      $display("[TB] FAIL w4_unsigned_max: got P=%h after %0d cycles, expected E1 after 5", p4, cyc);
    end
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 1000; i++) begin
        issue4(4'($urandom), 4'($urandom), 1'(mode));
        waitDone4(cyc);
        if (cyc < 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL random4_timeout: mode %0d op %0d never finished", mode, i);
        end
      end
    end
  endtask

  task automatic test_drain();
    repeat (3) @(posedge clock);
    #1;
    testsRun++;
    if (q8.size() != 0 || q4.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d/%0d results outstanding, expected 0/0", q8.size(), q4.size());
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_signed();
    test_corner();
    test_unsigned();
    test_back_to_back();
    test_reset_mid_run();
    test_random8();
    test_width4();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
